// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Keeps the fetch PC and exports PC+1 to the PC-select mux. Issues one
// outstanding instruction-memory read at a time and hands each fetched word
// to decode over a valid/ready handshake. A redirect (sel_pc) loads the PC
// from output_ALU. A response that was already in flight when the redirect
// arrived is drained and dropped, so the memory never sees a half request.
module pc_fetch_unit #(
   parameter int            AW           = 48,
   parameter int            IW           = 32,
   parameter logic [AW-1:0] RESET_VECTOR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   input  logic          sel_pc,
   input  logic [AW-1:0] output_ALU,
   output logic [AW-1:0] output_PC1,
   output logic [AW-1:0] pc_current,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [IW-1:0] instr_out,
   output logic [AW-1:0] instr_pc
);

   // IDLE : waiting for start
   // FETCH: issuing a read, or waiting for its ack
   // HOLD : fetched word is on instr_out, waiting for decode to take it
   // KILL : draining a response that a redirect has made stale
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      KILL  = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [AW-1:0] pc, pc_next;
   logic [AW-1:0] pc_inc;
   logic          req_next;
   logic [AW-1:0] addr_next;
   logic          valid_next;
   logic [IW-1:0] out_next;
   logic [AW-1:0] ipc_next;

   // PC+1 wraps silently at 2^AW. It is the sequential successor used by the
   // mux and by the PC update after a delivered fetch.
   assign pc_inc     = pc + AW'(1);
   assign output_PC1 = pc_inc;
   assign pc_current = pc;

   // Next-state and next-output logic for the fetch sequencer.
   always_comb begin
      // NOTE: every signal assigned here gets a default first; a branch that
      // leaves one unassigned would infer a latch.
      state_next = state;
      pc_next    = pc;
      req_next   = imem_req;
      addr_next  = imem_addr;
      valid_next = instr_valid;
      out_next   = instr_out;
      ipc_next   = instr_pc;

      unique case (state)
         IDLE: begin
            // A redirect while idle only reloads the PC.
            if (sel_pc) pc_next = output_ALU;
            if (start)  state_next = FETCH;
         end

         FETCH: begin
            if (!imem_req) begin
               // No read in flight. A redirect wins over stall and over
               // issuing. The request goes out next cycle from the new PC.
               if (sel_pc) begin
                  pc_next = output_ALU;
               end else if (!stall) begin
                  req_next  = 1'b1;
                  addr_next = pc;
               end
            end else if (sel_pc) begin
               // A read is in flight and has gone stale. Drop it now if it
               // completes this cycle, otherwise drain it in KILL.
               pc_next = output_ALU;
               if (imem_ack) req_next   = 1'b0;
               else          state_next = KILL;
            end else if (imem_ack) begin
               // A good response: latch it for decode and advance the PC.
               req_next   = 1'b0;
               valid_next = 1'b1;
               out_next   = imem_rdata;
               ipc_next   = pc;
               pc_next    = pc_inc;
               state_next = HOLD;
            end
         end

         HOLD: begin
            // A redirect drops the buffered word even if decode is taking it.
            if (sel_pc) begin
               pc_next    = output_ALU;
               valid_next = 1'b0;
               state_next = FETCH;
            end else if (instr_ready) begin
               valid_next = 1'b0;
               state_next = FETCH;
            end
         end

         KILL: begin
            // Hold the request until the stale response arrives, then
            // discard it. The last redirect seen here sets the PC.
            if (sel_pc) pc_next = output_ALU;
            if (imem_ack) begin
               req_next   = 1'b0;
               state_next = FETCH;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // State and output registers. Reset puts the unit back to IDLE at
   // RESET_VECTOR and abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_VECTOR;
         instr_valid <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= '0;
      end else begin
         // NOTE: registered state uses non-blocking assignments, so every
         // flop samples the values from before this edge.
         state       <= state_next;
         pc          <= pc_next;
         imem_req    <= req_next;
         imem_addr   <= addr_next;
         instr_valid <= valid_next;
         instr_out   <= out_next;
         instr_pc    <= ipc_next;
      end
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer: the consumer end of the PC-select path.
- Holds the 48-bit PC and exports PC+1 for the PC-select mux (sel_pc=0 → PC+1, sel_pc=1 → ALU branch target).
- Issues one-outstanding instruction-memory reads and delivers instructions to decode via a valid/ready handshake.
- Sits between the PC-select mux/ALU and instruction memory/decode.

Parameters:
- AW, 48, address/PC width
- IW, 32, instruction word width
- RESET_VECTOR, 48'h0, PC loaded at reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins fetching from current PC
- stall  in  1  freeze: no new request issued while high
- sel_pc  in  1  redirect request; target taken from output_ALU
- output_ALU  in  AW  branch/jump target
- output_PC1  out  AW  PC+1 of the current fetch PC, fed to the PC-select mux
- pc_current  out  AW  address of the current/next fetch
- imem_req  out  1  read request, held until imem_ack
- imem_addr  out  AW  read address, stable while imem_req=1
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid
- imem_rdata  in  IW  instruction word
- instr_valid  out  1  instr_out/instr_pc valid
- instr_ready  in  1  decode accepts when valid&ready
- instr_out  out  IW  fetched instruction
- instr_pc  out  AW  address of instr_out

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_VECTOR, state=IDLE.
  - imem_req=0, imem_addr=RESET_VECTOR, instr_valid=0, instr_out=0, instr_pc=0.
  - output_PC1=RESET_VECTOR+1, pc_current=RESET_VECTOR.
  - Deassertion is taken synchronously at the next clk edge.
- Arithmetic: output_PC1=PC+1 mod 2^AW; 48'hFFFF_FFFF_FFFF wraps to 0 and no flag is raised.
- States: IDLE, FETCH, HOLD, KILL.
- IDLE:
  - All outputs stay quiet.
  - start=1 → FETCH.
  - sel_pc in IDLE loads PC=output_ALU and stays in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=PC, both registered; the request appears the cycle after entry.
  - The request is issued only if stall=0. While stall=1, imem_req=0 and the unit remains in FETCH.
  - Once imem_req=1, it is held regardless of stall until imem_ack.
  - On imem_ack with no redirect pending: capture instr_out=imem_rdata and instr_pc=PC, set instr_valid=1, PC=PC+1 → HOLD. Latency is request to instr_valid = 1 cycle after ack.
- HOLD:
  - instr_valid stays high; instr_out/instr_pc are stable until accepted.
  - On instr_valid&instr_ready: instr_valid=0 next cycle → FETCH, with the next request on the following cycle.
- Redirect (sel_pc=1, sampled every cycle):
  - PC=output_ALU next cycle.
  - If HOLD: instr_valid clears next cycle, the buffered instruction is dropped even if instr_ready=1 in the same cycle → FETCH.
  - If FETCH with no request outstanding: the new PC is used for the request.
  - If FETCH with a request outstanding: → KILL.
- KILL:
  - imem_req is held until imem_ack.
  - The response is discarded: instr_valid stays 0 and PC is unchanged.
  - Then → FETCH at the redirected PC.
  - A further sel_pc in KILL overwrites PC; the last redirect wins.
- Simultaneous events:
  - sel_pc with imem_ack in the same FETCH cycle: the response is discarded, PC=output_ALU → FETCH.
  - sel_pc has priority over stall.
  - start is ignored outside IDLE.
- Reset mid-operation: returns immediately to the reset state and the outstanding request is abandoned. The memory must tolerate imem_req dropping.
- Throughput: one instruction per 3 cycles minimum with single-cycle ack and instr_ready tied high. There is no prefetch.

Test Plan:
- Reset then start, ack 1 cycle after each request, instr_ready=1 → imem_addr sequence 0,1,2,3; instr_pc=0,1,2,3; output_PC1 tracks PC+1.
- instr_ready=0 for 5 cycles while HOLD with instr_out=32'hDEADBEEF → instr_valid held and data stable; no imem_req until accept.
- Redirect while request outstanding (addr 2, sel_pc=1, output_ALU=48'h100, ack 3 cycles later) → response discarded; next imem_addr=48'h100; instr_pc of next delivered instruction=48'h100.
- sel_pc and imem_ack in same cycle, target 48'h40 → no instr_valid; next request at 48'h40.
- RESET_VECTOR=48'hFFFF_FFFF_FFFF → first fetch at all-ones, output_PC1=0, second fetch at 0.
- stall=1 for 4 cycles in FETCH, then a mid-fetch rst_n pulse → no imem_req during stall; after reset all outputs at reset values and state IDLE until start.
